// File: rtl/batcharger_adc_sequencer_if.sv
// ADC/mux side of the charger measurement sequencer: mux select, start pulse, result return.
interface batcharger_adc_sequencer_if;
    logic [1:0] adc_sel;
    logic       adc_start;
    logic       adc_eoc;
    logic [7:0] adc_data;

    modport master (output adc_sel, adc_start, input adc_eoc, adc_data);
    modport slave  (input adc_sel, adc_start, output adc_eoc, adc_data);
endinterface

// File: rtl/batcharger_adc_sequencer.sv
// Round-robin scanner sharing one 8-bit ADC between battery voltage, current and temperature.
module batcharger_adc_sequencer #(
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                              clk,
    input  logic                              rstz,
    input  logic                              en,
    input  logic                              vmonen,
    input  logic                              imonen,
    input  logic                              tmonen,
    batcharger_adc_sequencer_if.master        adc,
    output logic [7:0]                        vbat,
    output logic [7:0]                        ibat,
    output logic [7:0]                        tbat,
    output logic                              vtok,
    output logic                              adc_err,
    output logic                              busy
);

    localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, ARB, SETTLE, CONV} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sel_q, sel_d, rr_q, rr_d, pick, scan;
    logic          start_q, start_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic [7:0]    vbat_d, ibat_d, tbat_d;
    logic [2:0]    valid_q, valid_d;
    logic          vtok_d, err_d, busy_d, found, sel_on;
    logic [3:0]    mon;

    function automatic logic [1:0] nxt(input logic [1:0] c);
        return (c == 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

    assign adc.adc_sel   = sel_q;
    assign adc.adc_start = start_q;

    // Bit 3 pads the enable vector so a 2-bit select can index it safely.
    always_comb begin
        mon    = {1'b0, tmonen, imonen, vmonen};
        found  = 1'b0;
        pick   = rr_q;
        scan   = rr_q;
        for (int unsigned i = 0; i < 3; i++) begin
            if (!found && mon[scan]) begin
                found = 1'b1;
                pick  = scan;
            end
            scan = nxt(scan);
        end
        sel_on = mon[sel_q];
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_d     = rr_q;
        start_d  = 1'b0;
        settle_d = settle_q;
        wdog_d   = wdog_q;
        vbat_d   = vbat;
        ibat_d   = ibat;
        tbat_d   = tbat;
        valid_d  = valid_q & mon[2:0];
        err_d    = adc_err;

        case (state_q)
            IDLE: begin
                if (|mon) state_d = ARB;
            end
            ARB: begin
                if (found) begin
                    sel_d    = pick;
                    settle_d = SW'(SETTLE_CYC - 1);
                    state_d  = SETTLE;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (!sel_on) begin
                    state_d = ARB;
                    rr_d    = nxt(sel_q);
                end else if (settle_q == '0) begin
                    state_d = CONV;
                    start_d = 1'b1;
                    wdog_d  = WW'(1);
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            CONV: begin
                // Channel drop outranks eoc, and eoc outranks watchdog expiry.
                if (!sel_on) begin
                    state_d = ARB;
                    rr_d    = nxt(sel_q);
                end else if (!start_q && adc.adc_eoc) begin
                    case (sel_q)
                        2'd0:    begin vbat_d = adc.adc_data; valid_d[0] = 1'b1; end
                        2'd1:    begin ibat_d = adc.adc_data; valid_d[1] = 1'b1; end
                        default: begin tbat_d = adc.adc_data; valid_d[2] = 1'b1; end
                    endcase
                    rr_d    = nxt(sel_q);
                    state_d = ARB;
                end else if (wdog_q >= WW'(TIMEOUT_CYC)) begin
                    err_d   = 1'b1;
                    rr_d    = nxt(sel_q);
                    state_d = ARB;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!en) begin
            state_d = IDLE;
            start_d = 1'b0;
            valid_d = '0;
            err_d   = 1'b0;
        end

        vtok_d = valid_d[0] & valid_d[2];
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rr_q     <= '0;
            start_q  <= 1'b0;
            settle_q <= '0;
            wdog_q   <= '0;
            vbat     <= '0;
            ibat     <= '0;
            tbat     <= '0;
            valid_q  <= '0;
            vtok     <= 1'b0;
            adc_err  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_q     <= rr_d;
            start_q  <= start_d;
            settle_q <= settle_d;
            wdog_q   <= wdog_d;
            vbat     <= vbat_d;
            ibat     <= ibat_d;
            tbat     <= tbat_d;
            valid_q  <= valid_d;
            vtok     <= vtok_d;
            adc_err  <= err_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_batcharger_adc_sequencer.sv
// Scoreboard bench: a reactive ADC model predicts accepted samples/timeouts, a monitor checks registers.
module tb_batcharger_adc_sequencer;
    localparam int SETTLE = 4;
    localparam int TMO    = 64;

    logic       clk = 1'b0, rstz = 1'b0, en = 1'b0;
    logic       vmonen = 1'b0, imonen = 1'b0, tmonen = 1'b0;
    logic [7:0] vbat, ibat, tbat;
    logic       vtok, adc_err, busy;

    batcharger_adc_sequencer_if bus();

    batcharger_adc_sequencer #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rstz(rstz), .en(en),
        .vmonen(vmonen), .imonen(imonen), .tmonen(tmonen),
        .adc(bus),
        .vbat(vbat), .ibat(ibat), .tbat(tbat),
        .vtok(vtok), .adc_err(adc_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    typedef struct {bit tmo; int ch; logic [7:0] d; time due;} exp_t;
    exp_t q[$];

    logic [7:0] adc_val [3];
    int         eoc_k   [3];
    bit         no_eoc  [3];
    bit         use_table = 1'b1;
    bit         rr_known  = 1'b1;
    int         mrr       = 0;

    logic [7:0] exp_reg [3];
    logic [2:0] mvalid   = '0;
    logic       merr     = 1'b0;
    logic [2:0] last_mon = '0;
    logic       last_en  = 1'b0;

    function automatic logic [2:0] monv();
        return {tmonen, imonen, vmonen};
    endfunction

    function automatic int pick_ch(int p, logic [2:0] m);
        for (int i = 0; i < 3; i++)
            if (m[(p + i) % 3]) return (p + i) % 3;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_start(output logic [1:0] sel, output int n);
        n = 0;
        sel = '0;
        forever begin
            @(negedge clk);
            n++;
            if (bus.adc_start) begin
                sel = bus.adc_sel;
                return;
            end
            if (n >= 300) begin
                checks++;
                errors++;
                $display("FAIL start_timeout: no adc_start within %0d cycles at %0t", n, $time);
                return;
            end
        end
    endtask

    task automatic wait_sel(input logic [1:0] target);
        logic [1:0] s;
        int n;
        for (int i = 0; i < 6; i++) begin
            wait_start(s, n);
            if (s == target) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_sel: channel %0d never started, last 0x%0h", target, s);
    endtask

    // ADC model: answers each start after eoc_k cycles (or never), predicting what the DUT must do.
    initial begin : adc_model
        int ch, k;
        bit ab, noe;
        logic [7:0] d;
        logic [2:0] m;
        bus.adc_eoc  = 1'b0;
        bus.adc_data = '0;
        forever begin
            @(negedge clk);
            if (rstz && bus.adc_start) begin
                ch = int'(bus.adc_sel);
                m  = monv();
                if (rr_known) chk("sel_rr", 32'(bus.adc_sel), pick_ch(mrr, m));
                k   = eoc_k[ch];
                noe = no_eoc[ch];
                d   = use_table ? adc_val[ch] : 8'($urandom_range(0, 255));
                ab  = !(en && m[ch]);
                for (int j = 1; j <= (noe ? TMO - 1 : k); j++) begin
                    if (noe && ab) break;
                    @(posedge clk); #1;
                    if (!noe && j == k) begin
                        bus.adc_eoc  = 1'b1;
                        bus.adc_data = d;
                    end
                    @(negedge clk);
                    m = monv();
                    if (!(en && m[ch])) ab = 1'b1;
                end
                if (!ab) begin
                    q.push_back('{noe, ch, d, $time + 10});
                    mrr      = (ch + 1) % 3;
                    rr_known = 1'b1;
                end else begin
                    rr_known = 1'b0;
                end
                if (!noe) begin
                    @(posedge clk); #1;
                    bus.adc_eoc = 1'b0;
                end
            end
        end
    end

    // Monitor: retires due predictions and compares every registered output each cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rstz) begin
                exp_reg = '{8'h00, 8'h00, 8'h00};
                mvalid  = '0;
                merr    = 1'b0;
            end else begin
                if (!last_en) begin
                    mvalid = '0;
                    merr   = 1'b0;
                end else begin
                    mvalid = mvalid & last_mon;
                end
                while (q.size() > 0 && q[0].due <= $time) begin
                    e = q.pop_front();
                    if (e.tmo) merr = 1'b1;
                    else begin
                        exp_reg[e.ch] = e.d;
                        mvalid[e.ch]  = 1'b1;
                    end
                end
                chk("vbat", vbat, exp_reg[0]);
                chk("ibat", ibat, exp_reg[1]);
                chk("tbat", tbat, exp_reg[2]);
                chk("vtok", vtok, mvalid[0] & mvalid[2]);
                chk("adc_err", adc_err, merr);
            end
            last_mon = monv();
            last_en  = en;
        end
    end

    initial begin : guard
        #600000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin : main
        logic [1:0] s [4];
        logic [1:0] sel;
        int n;
        adc_val = '{8'h99, 8'h66, 8'h64};
        eoc_k   = '{3, 3, 3};
        no_eoc  = '{1'b0, 1'b0, 1'b0};

        // Reset values
        @(negedge clk);
        chk("rst_sel", bus.adc_sel, 0);
        chk("rst_start", bus.adc_start, 0);
        chk("rst_vbat", vbat, 0);
        chk("rst_ibat", ibat, 0);
        chk("rst_tbat", tbat, 0);
        chk("rst_vtok", vtok, 0);
        chk("rst_err", adc_err, 0);
        chk("rst_busy", busy, 0);
        step(2);
        rstz = 1'b1;

        // Full scan V, I, T, V with fixed results
        step(1);
        en = 1'b1;
        {tmonen, imonen, vmonen} = 3'b111;
        n = 0;
        do begin @(negedge clk); n++; end while (!busy && n < 20);
        chk("busy_rise", busy, 1);
        wait_start(s[0], n);
        chk("arb_to_start", n, SETTLE + 1);
        for (int i = 1; i < 4; i++) wait_start(s[i], n);
        chk("seq0", s[0], 0);
        chk("seq1", s[1], 1);
        chk("seq2", s[2], 2);
        chk("seq3", s[3], 0);
        chk("vtok_up", vtok, 1);
        chk("vbat_99", vbat, 8'h99);
        chk("ibat_66", ibat, 8'h66);
        chk("tbat_64", tbat, 8'h64);

        // Current channel never answers: watchdog expiry
        no_eoc[1] = 1'b1;
        wait_sel(2'd1);
        repeat (TMO - 1) @(negedge clk);
        chk("err_before_tmo", adc_err, 0);
        @(negedge clk);
        chk("err_at_tmo", adc_err, 1);
        no_eoc[1] = 1'b0;
        wait_start(sel, n);
        chk("sel_after_tmo", sel, 2);
        chk("ibat_kept", ibat, 8'h66);

        // Enable dropped during settling
        wait_start(sel, n);
        step(6);
        en = 1'b0;
        rr_known = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("en0_busy", busy, 0);
        chk("en0_vtok", vtok, 0);
        chk("en0_err", adc_err, 0);
        chk("en0_vbat", vbat, 8'h99);
        chk("en0_start", bus.adc_start, 0);

        // Current channel disabled: V and T alternate
        step(2);
        {tmonen, imonen, vmonen} = 3'b101;
        en = 1'b1;
        rr_known = 1'b0;
        wait_start(s[0], n);
        chk("noi_sel0", {31'd0, s[0] == 2'd1}, 0);
        for (int i = 1; i < 4; i++) begin
            wait_start(s[i], n);
            chk("noi_sel", {31'd0, s[i] == 2'd1}, 0);
            chk("noi_alt", {31'd0, s[i] != s[i-1]}, 1);
        end
        chk("noi_vtok", vtok, 1);

        // Temperature enable dropped mid-conversion; its late eoc must be ignored
        imonen = 1'b1;
        adc_val[2] = 8'hAA;
        eoc_k[2]   = 5;
        wait_sel(2'd2);
        step(1);
        tmonen = 1'b0;
        rr_known = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("tdrop_busy", busy, 1);
        chk("tdrop_vtok", vtok, 0);
        @(negedge clk);
        chk("tdrop_sel", bus.adc_sel, 0);
        step(8);
        chk("tdrop_tbat", tbat, 8'h64);
        chk("tdrop_err", adc_err, 0);
        tmonen   = 1'b1;
        eoc_k[2] = 3;

        // eoc on the same cycle the watchdog expires
        adc_val[0] = 8'h3C;
        eoc_k[0]   = TMO - 1;
        wait_sel(2'd0);
        repeat (TMO) @(negedge clk);
        chk("coinc_err", adc_err, 0);
        chk("coinc_vbat", vbat, 8'h3C);
        eoc_k[0] = 3;

        // Randomized enables, latencies, timeouts and data
        use_table = 1'b0;
        for (int it = 0; it < 30; it++) begin
            int r;
            step(1);
            r = $urandom_range(0, 7);
            {tmonen, imonen, vmonen} = (r == 0) ? 3'b000 : 3'($urandom_range(1, 7));
            en = (r != 1);
            for (int c = 0; c < 3; c++) begin
                eoc_k[c]  = $urandom_range(1, 5);
                no_eoc[c] = ($urandom_range(0, 9) == 0);
            end
            rr_known = 1'b0;
            step($urandom_range(10, 80));
        end

        step(1);
        no_eoc = '{1'b0, 1'b0, 1'b0};
        {tmonen, imonen, vmonen} = 3'b111;
        en = 1'b1;
        rr_known = 1'b0;
        step(150);
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
